// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared constants and types for the MIPS pipeline stages:
//               next-PC select encodings, special instruction words, default
//               widths and the fetch-stage state type.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int BITS_PC_DEFAULT    = 32;
    localparam int BITS_INSTR_DEFAULT = 32;

    // Next-PC source select
    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_JREG   = 2'b11;

    // Special instruction words
    localparam logic [31:0] INSTR_HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] INSTR_NOP  = 32'h0000_0000;

    // Fetch control state
    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } if_state_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/instruction_memory.sv
`default_nettype none
// ============================================================================
// Module      : instruction_memory
// Description : Word-organised instruction store. Combinational read port for
//               the fetch path, synchronous write port for the debug loader.
//               Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_memory #(
    parameter int BITS_INSTR    = 32,
    parameter int MEM_DEPTH     = 64,
    parameter int BITS_MEM_ADDR = 6
) (
    input  logic                     i_clk,
    input  logic                     i_wr_en,
    input  logic [BITS_MEM_ADDR-1:0] i_wr_addr,
    input  logic [BITS_INSTR-1:0]    i_wr_data,
    input  logic [BITS_MEM_ADDR-1:0] i_rd_addr,
    output logic [BITS_INSTR-1:0]    o_rd_data
);

    logic [BITS_INSTR-1:0] r_mem [MEM_DEPTH];

    // Loader write port
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule : instruction_memory
`default_nettype wire

// File: rtl/stage_if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : stage_if_fetch
// Description : IF stage of the 5-stage MIPS pipeline. Owns the PC, the
//               debug-loadable instruction memory and the IF/ID latch.
//               Handles stall, flush/redirect and HALT detection.
//               Optional macro IF_STEP_EN adds i_step single-step gating.
// Revision    : 1.0 - initial release
// ============================================================================
module stage_if_fetch
    import mips_pkg::*;
#(
    parameter int BITS_PC       = BITS_PC_DEFAULT,
    parameter int BITS_INSTR    = BITS_INSTR_DEFAULT,
    parameter int MEM_DEPTH     = 64,
    parameter int BITS_MEM_ADDR = 6
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_enable,
    input  logic                     i_stall,
    input  logic                     i_flush,
    input  logic [1:0]               i_pc_src,
    input  logic [BITS_PC-1:0]       i_branch_target,
    input  logic [BITS_PC-1:0]       i_jump_target,
    input  logic [BITS_PC-1:0]       i_jr_target,
    input  logic                     i_mem_wr_en,
    input  logic [BITS_MEM_ADDR-1:0] i_mem_wr_addr,
    input  logic [BITS_INSTR-1:0]    i_mem_wr_data,
`ifdef IF_STEP_EN
    input  logic                     i_step,
`endif
    output logic [BITS_PC-1:0]       o_pc,
    output logic [BITS_PC-1:0]       o_pc_plus4,
    output logic [BITS_INSTR-1:0]    o_instruction,
    output logic                     o_valid,
    output logic                     o_halt
);

    localparam logic [BITS_INSTR-1:0] c_HALT = BITS_INSTR'(INSTR_HALT);
    localparam logic [BITS_INSTR-1:0] c_NOP  = BITS_INSTR'(INSTR_NOP);

    logic [BITS_PC-1:0]    r_pc;
    logic [BITS_PC-1:0]    w_pc_plus4;
    logic [BITS_PC-1:0]    w_pc_next;
    logic [BITS_INSTR-1:0] w_mem_rdata;
    logic                  w_go;
    logic                  w_advance;
    logic                  w_halt_fetch;
    if_state_t             r_state;
    if_state_t             w_state_next;

    // Target low bits are forced to zero, so they are intentionally dropped.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, i_branch_target[1:0], i_jump_target[1:0], i_jr_target[1:0]};

    instruction_memory #(
        .BITS_INSTR    (BITS_INSTR),
        .MEM_DEPTH     (MEM_DEPTH),
        .BITS_MEM_ADDR (BITS_MEM_ADDR)
    ) u_imem (
        .i_clk     (i_clk),
        .i_wr_en   (i_mem_wr_en && !i_enable),
        .i_wr_addr (i_mem_wr_addr),
        .i_wr_data (i_mem_wr_data),
        .i_rd_addr (r_pc[BITS_MEM_ADDR+1:2]),
        .o_rd_data (w_mem_rdata)
    );

`ifdef IF_STEP_EN
    assign w_go = i_step;
`else
    assign w_go = 1'b1;
`endif

    assign w_pc_plus4   = r_pc + BITS_PC'(4);
    assign w_advance    = i_enable && !i_stall && w_go && (r_state == ST_RUN);
    assign w_halt_fetch = w_advance && !i_flush && (w_mem_rdata == c_HALT);

    // Next-PC select; redirect targets are word aligned
    always_comb begin
        w_pc_next = w_pc_plus4;
        case (i_pc_src)
            PC_SRC_BRANCH: w_pc_next = {i_branch_target[BITS_PC-1:2], 2'b00};
            PC_SRC_JUMP:   w_pc_next = {i_jump_target[BITS_PC-1:2], 2'b00};
            PC_SRC_JREG:   w_pc_next = {i_jr_target[BITS_PC-1:2], 2'b00};
            default:       w_pc_next = w_pc_plus4;
        endcase
    end

    // Fetch state register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: HALTED is only left through reset
    always_comb begin
        w_state_next = r_state;
        o_halt       = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_halt_fetch) begin
                    w_state_next = ST_HALTED;
                end
            end
            ST_HALTED: begin
                o_halt = 1'b1;
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    // PC: a flush redirects even under stall; a fetched HALT freezes the PC
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pc <= '0;
        end else if (i_enable && (r_state == ST_RUN)) begin
            if (i_flush) begin
                r_pc <= w_pc_next;
            end else if (w_advance && !w_halt_fetch) begin
                r_pc <= w_pc_next;
            end
        end
    end

    // IF/ID latch: disable > flush > stall > advance > halted bubble
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_instruction <= c_NOP;
            o_pc_plus4    <= '0;
            o_valid       <= 1'b0;
        end else if (!i_enable) begin
            o_valid <= o_valid;
        end else if (i_flush) begin
            o_instruction <= c_NOP;
            o_pc_plus4    <= w_pc_plus4;
            o_valid       <= 1'b0;
        end else if (i_stall) begin
            o_valid <= o_valid;
        end else if (w_advance) begin
            o_instruction <= w_mem_rdata;
            o_pc_plus4    <= w_pc_plus4;
            o_valid       <= 1'b1;
        end else if (r_state == ST_HALTED) begin
            o_instruction <= c_NOP;
            o_valid       <= 1'b0;
        end
    end

    assign o_pc = r_pc;

endmodule : stage_if_fetch
`default_nettype wire

// File: tb/tb_stage_if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_if_fetch
// Description : Directed self-checking bench for stage_if_fetch. Build with
//               IF_STEP_EN defined to include the single-step sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_if_fetch;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic        i_stall;
    logic        i_flush;
    logic [1:0]  i_pc_src;
    logic [31:0] i_branch_target;
    logic [31:0] i_jump_target;
    logic [31:0] i_jr_target;
    logic        i_mem_wr_en;
    logic [5:0]  i_mem_wr_addr;
    logic [31:0] i_mem_wr_data;
`ifdef IF_STEP_EN
    logic        i_step;
`endif
    logic [31:0] o_pc;
    logic [31:0] o_pc_plus4;
    logic [31:0] o_instruction;
    logic        o_valid;
    logic        o_halt;

    int checks   = 0;
    int failures = 0;

    stage_if_fetch dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_enable        (i_enable),
        .i_stall         (i_stall),
        .i_flush         (i_flush),
        .i_pc_src        (i_pc_src),
        .i_branch_target (i_branch_target),
        .i_jump_target   (i_jump_target),
        .i_jr_target     (i_jr_target),
        .i_mem_wr_en     (i_mem_wr_en),
        .i_mem_wr_addr   (i_mem_wr_addr),
        .i_mem_wr_data   (i_mem_wr_data),
`ifdef IF_STEP_EN
        .i_step          (i_step),
`endif
        .o_pc            (o_pc),
        .o_pc_plus4      (o_pc_plus4),
        .o_instruction   (o_instruction),
        .o_valid         (o_valid),
        .o_halt          (o_halt)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [5:0] addr, input logic [31:0] data);
        i_enable      = 1'b0;
        i_mem_wr_en   = 1'b1;
        i_mem_wr_addr = addr;
        i_mem_wr_data = data;
        tick();
        i_mem_wr_en   = 1'b0;
    endtask

    task automatic pulse_reset();
        i_reset = 1'b1;
        #1;
        i_reset = 1'b0;
    endtask

    initial begin
        i_reset = 1'b1; i_enable = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
        i_pc_src = 2'b00; i_branch_target = '0; i_jump_target = '0; i_jr_target = '0;
        i_mem_wr_en = 1'b0; i_mem_wr_addr = '0; i_mem_wr_data = '0;
`ifdef IF_STEP_EN
        i_step = 1'b1;
`endif
        tick();
        check("rst_pc", o_pc, 32'h0);
        check("rst_pc4", o_pc_plus4, 32'h0);
        check("rst_instr", o_instruction, 32'h0);
        check("rst_valid", o_valid, 32'h0);
        check("rst_halt", o_halt, 32'h0);
        i_reset = 1'b0;

        // Program image
        load(6'd0, 32'h2001_0005);
        load(6'd1, 32'h2002_0003);
        load(6'd2, 32'hFFFF_FFFF);
        load(6'd3, 32'hAC01_0003);
        load(6'd4, 32'h8C03_0000);
        load(6'd8, 32'h0043_0820);
        check("load_pc_frozen", o_pc, 32'h0);
        check("load_valid", o_valid, 32'h0);

        // Sequential fetch into HALT
        i_enable = 1'b1;
        tick();
        check("seq0_instr", o_instruction, 32'h2001_0005);
        check("seq0_pc4", o_pc_plus4, 32'h4);
        check("seq0_valid", o_valid, 32'h1);
        check("seq0_pc", o_pc, 32'h4);
        tick();
        check("seq1_instr", o_instruction, 32'h2002_0003);
        check("seq1_pc4", o_pc_plus4, 32'h8);
        check("seq1_pc", o_pc, 32'h8);
        tick();
        check("seq2_instr", o_instruction, 32'hFFFF_FFFF);
        check("seq2_pc4", o_pc_plus4, 32'hC);
        check("seq2_valid", o_valid, 32'h1);
        check("seq2_pc", o_pc, 32'h8);
        check("seq2_halt", o_halt, 32'h1);
        tick();
        check("halted_valid", o_valid, 32'h0);
        check("halted_instr", o_instruction, 32'h0);
        check("halted_pc", o_pc, 32'h8);
        i_flush = 1'b1; i_pc_src = 2'b10; i_jump_target = 32'h10;
        tick();
        check("halted_flush_pc", o_pc, 32'h8);
        check("halted_flush_halt", o_halt, 32'h1);
        i_flush = 1'b0; i_pc_src = 2'b00;

        // Stall holds PC and IF/ID
        pulse_reset();
        check("rst2_halt", o_halt, 32'h0);
        tick();
        check("pre_stall_pc", o_pc, 32'h4);
        i_stall = 1'b1;
        tick();
        tick();
        check("stall_pc", o_pc, 32'h4);
        check("stall_instr", o_instruction, 32'h2001_0005);
        check("stall_valid", o_valid, 32'h1);
        i_stall = 1'b0;
        tick();
        check("post_stall_instr", o_instruction, 32'h2002_0003);
        check("post_stall_pc", o_pc, 32'h8);

        // Flush + branch while HALT sits at PC
        i_flush = 1'b1; i_pc_src = 2'b01; i_branch_target = 32'h23;
        tick();
        check("flush_instr", o_instruction, 32'h0);
        check("flush_valid", o_valid, 32'h0);
        check("flush_pc", o_pc, 32'h20);
        check("flush_pc4", o_pc_plus4, 32'hC);
        check("flush_halt", o_halt, 32'h0);
        i_flush = 1'b0; i_pc_src = 2'b00;
        tick();
        check("br_instr", o_instruction, 32'h0043_0820);
        check("br_pc", o_pc, 32'h24);

        // Flush beats stall, HALT squashed
        pulse_reset();
        tick();
        tick();
        check("pre_fs_pc", o_pc, 32'h8);
        i_flush = 1'b1; i_stall = 1'b1; i_pc_src = 2'b10; i_jump_target = 32'h10;
        tick();
        check("fs_pc", o_pc, 32'h10);
        check("fs_valid", o_valid, 32'h0);
        check("fs_halt", o_halt, 32'h0);
        i_flush = 1'b0; i_stall = 1'b0; i_pc_src = 2'b00;
        tick();
        check("fs_next_instr", o_instruction, 32'h8C03_0000);
        check("fs_next_pc", o_pc, 32'h14);

        // Write while enabled is ignored
        i_stall = 1'b1; i_mem_wr_en = 1'b1; i_mem_wr_addr = 6'd3; i_mem_wr_data = 32'h1234_5678;
        tick();
        i_mem_wr_en = 1'b0; i_stall = 1'b0;
        i_flush = 1'b1; i_pc_src = 2'b11; i_jr_target = 32'h0E;
        tick();
        check("jr_pc_aligned", o_pc, 32'hC);
        i_flush = 1'b0; i_pc_src = 2'b00;
        tick();
        check("wr_gate_instr", o_instruction, 32'hAC01_0003);

        // High PC bits alias onto the same memory word
        i_flush = 1'b1; i_pc_src = 2'b10; i_jump_target = 32'h104;
        tick();
        check("alias_pc", o_pc, 32'h104);
        i_flush = 1'b0; i_pc_src = 2'b00;
        tick();
        check("alias_instr", o_instruction, 32'h2002_0003);
        check("alias_pc4", o_pc_plus4, 32'h108);

        // Asynchronous reset mid-cycle
        #2;
        i_reset = 1'b1;
        #1;
        check("arst_pc", o_pc, 32'h0);
        check("arst_pc4", o_pc_plus4, 32'h0);
        check("arst_instr", o_instruction, 32'h0);
        check("arst_valid", o_valid, 32'h0);
        #1;
        i_reset = 1'b0;
        tick();
        check("arst_restart_instr", o_instruction, 32'h2001_0005);

`ifdef IF_STEP_EN
        // Single-step fetch
        load(6'd2, 32'h0022_1820);
        pulse_reset();
        i_enable = 1'b1; i_step = 1'b0;
        tick();
        tick();
        check("step_idle_pc", o_pc, 32'h0);
        check("step_idle_valid", o_valid, 32'h0);
        i_step = 1'b1;
        tick();
        i_step = 1'b0;
        check("step1_pc", o_pc, 32'h4);
        check("step1_instr", o_instruction, 32'h2001_0005);
        tick();
        check("step_gap_pc", o_pc, 32'h4);
        i_step = 1'b1;
        tick();
        i_step = 1'b0;
        check("step2_instr", o_instruction, 32'h2002_0003);
        tick();
        check("step_gap2_pc", o_pc, 32'h8);
        i_step = 1'b1;
        tick();
        i_step = 1'b0;
        check("step3_instr", o_instruction, 32'h0022_1820);
        check("step3_pc", o_pc, 32'hC);
        tick();
        check("step_final_pc", o_pc, 32'hC);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_stage_if_fetch
`default_nettype wire
